if_stage16: RTL and testbench
=============================

IF_STAGE16 -- requirements
Module: if_stage16

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of cycles without imem_rvalid (range 1..255) after which fetch_err is set.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 pc  input  16  current PC from the program counter register.
REQ-005 pc_enable  output  1  PC update enable, driven to the program counter's enable input.
REQ-006 imem_req  output  1  instruction memory request.
REQ-007 imem_addr  output  16  request word address.
REQ-008 imem_gnt  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid  input  1  response data valid; at least 1 cycle after gnt.
REQ-010 imem_rdata  input  16  instruction word.
REQ-011 flush  input  1  redirect from execute (branch taken or jalr); pc_sel is valid in the same cycle.
REQ-012 id_valid  output  1  decode register holds an instruction.
REQ-013 id_instr  output  16  held instruction.
REQ-014 id_pc  output  16  address of the held instruction.
REQ-015 id_ready  input  1  decode consumes id_instr this cycle.
REQ-016 fetch_err  output  1  sticky protocol/timeout error.

Function
REQ-017 The FSM SHALL have four states: REQ, WAIT, DRAIN and HOLD, with at most one outstanding memory request.
REQ-018 REQ: imem_req=1 and imem_addr=pc; gnt moves to WAIT and captures pc into an address register; no gnt stays in REQ.
REQ-019 imem_addr SHALL equal pc in REQ and equal the captured address in all other states.
REQ-020 imem_req SHALL be 0 in every state except REQ.
REQ-021 WAIT: on rvalid, the block SHALL load id_instr=imem_rdata, load id_pc=captured address, set id_valid=1 and move to HOLD.
REQ-022 HOLD: id_valid=1 and id_instr/id_pc held stable; on id_ready, pc_enable=1 combinationally in that cycle, id_valid clears at the edge and the FSM moves to REQ.
REQ-023 pc_enable SHALL be 1 exactly when (HOLD and id_ready and not flush) or flush; otherwise it SHALL be 0.
REQ-024 With a 1-cycle memory, steady-state throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD).
REQ-025 flush in REQ without gnt: the FSM SHALL stay in REQ and present the new pc next cycle.
REQ-026 flush in REQ with gnt: the FSM SHALL go to DRAIN.
REQ-027 flush in WAIT without rvalid: the FSM SHALL go to DRAIN.
REQ-028 flush in WAIT with rvalid: the data SHALL be discarded and the FSM SHALL go to REQ.
REQ-029 flush in HOLD: id_valid SHALL clear and the FSM SHALL go to REQ; flush SHALL take priority over id_ready.
REQ-030 DRAIN: on rvalid, the response SHALL be discarded without updating id_* and the FSM SHALL go to REQ; flush in DRAIN SHALL stay in DRAIN.
REQ-031 A wait counter (8-bit) SHALL clear on entry to WAIT or DRAIN, increment each cycle in those states without rvalid, and saturate at 255.
REQ-032 When the counter reaches TIMEOUT, fetch_err SHALL be set; the FSM SHALL keep waiting.
REQ-033 rvalid in REQ or HOLD SHALL be ignored (no change to id_* or state) and SHALL set fetch_err.
REQ-034 Once set, fetch_err SHALL remain 1 until reset.
REQ-035 id_pc SHALL wrap naturally: a fetch at 0xFFFF is legal, with no special case.

Reset
REQ-036 Asserting reset SHALL immediately force: state=REQ, id_valid=0, id_instr=0, id_pc=0, captured address=0, counter=0, fetch_err=0.
REQ-037 While reset is high, imem_req and pc_enable SHALL be forced to 0.
REQ-038 Reset during WAIT or DRAIN SHALL abandon the outstanding request; a late rvalid arriving in REQ after reset SHALL set fetch_err per REQ-033 (the bench must not drive it).
REQ-039 imem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-040 Basic fetch: pc=0x0010, gnt in cycle 1, rvalid rdata=0xA5C3 in cycle 2, id_ready=1 -> id_valid=1 with id_instr=0xA5C3 and id_pc=0x0010; pc_enable=1 for exactly 1 cycle.
REQ-041 Decode stall: id_ready=0 for 5 cycles -> id_* stable, imem_req=0 and pc_enable=0 throughout; id_ready=1 -> a single pc_enable pulse, then REQ.
REQ-042 Flush in WAIT: flush=1 after gnt at 0x0020, rdata 0x1111 arrives 2 cycles later -> discarded, id_valid stays 0; the next request uses the redirected pc=0x0040.
REQ-043 Flush and id_ready together in HOLD -> id_valid=0, a single pc_enable pulse, no instruction consumed twice.
REQ-044 Timeout: TIMEOUT=4, no rvalid after gnt -> fetch_err=1 after the 4th wait cycle; a later rvalid=0xBEEF still loads id_instr; fetch_err stays 1 until reset.
REQ-045 Async reset mid-HOLD (id_valid=1) -> id_valid=0, id_instr=0 and imem_req=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_stage16.sv
// Instruction fetch stage for a 16-bit core. One outstanding memory request, a
// single decode holding register, flush redirect handling and a sticky error flag.
module if_stage16 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic        pc_enable,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    input  logic        id_ready,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] CNT_MAX_C = 8'hFF;

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] addr_r;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_next_s;
    logic        id_valid_r;
    logic [15:0] id_instr_r;
    logic [15:0] id_pc_r;
    logic        fetch_err_r;

    logic        cap_addr_s;
    logic        load_id_s;
    logic        clr_id_s;
    logic        cnt_clr_s;
    logic        cnt_inc_s;
    logic        spurious_s;
    logic        waiting_s;
    logic        timeout_hit_s;

    // Next-state decode and per-state control strobes.
    always_comb begin
        next_state_s = state_r;
        cap_addr_s   = 1'b0;
        load_id_s    = 1'b0;
        clr_id_s     = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        spurious_s   = 1'b0;
        case (state_r)
            S_REQ: begin
                // A response with nothing outstanding is a protocol error.
                spurious_s = imem_rvalid;
                if (imem_gnt) begin
                    cap_addr_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    if (flush) begin
                        next_state_s = S_DRAIN;
                    end else begin
                        next_state_s = S_WAIT;
                    end
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        next_state_s = S_REQ;
                    end else begin
                        load_id_s    = 1'b1;
                        next_state_s = S_HOLD;
                    end
                end else begin
                    cnt_inc_s = 1'b1;
                    if (flush) begin
                        cnt_clr_s    = 1'b1;
                        next_state_s = S_DRAIN;
                    end else begin
                        next_state_s = S_WAIT;
                    end
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    next_state_s = S_REQ;
                end else begin
                    cnt_inc_s    = 1'b1;
                    next_state_s = S_DRAIN;
                end
            end
            S_HOLD: begin
                spurious_s = imem_rvalid;
                if (flush || id_ready) begin
                    clr_id_s     = 1'b1;
                    next_state_s = S_REQ;
                end else begin
                    next_state_s = S_HOLD;
                end
            end
            default: begin
                next_state_s = S_REQ;
            end
        endcase
    end

    // Saturating wait counter next value.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_clr_s) begin
            cnt_next_s = 8'd0;
        end else if (cnt_inc_s && (cnt_r != CNT_MAX_C)) begin
            cnt_next_s = cnt_r + 8'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    assign waiting_s     = (state_r == S_WAIT) || (state_r == S_DRAIN);
    assign timeout_hit_s = waiting_s && (cnt_next_s >= TIMEOUT_C);

    // State, captured address and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_REQ;
            addr_r  <= 16'h0000;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            if (cap_addr_s) begin
                addr_r <= pc;
            end
        end
    end

    // Decode holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_r <= 1'b0;
            id_instr_r <= 16'h0000;
            id_pc_r    <= 16'h0000;
        end else if (load_id_s) begin
            id_valid_r <= 1'b1;
            id_instr_r <= imem_rdata;
            id_pc_r    <= addr_r;
        end else if (clr_id_s) begin
            id_valid_r <= 1'b0;
        end
    end

    // Sticky error: timeout or response with no request outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err_r <= 1'b0;
        end else if (timeout_hit_s || spurious_s) begin
            fetch_err_r <= 1'b1;
        end
    end

    // Request and PC-enable are combinational so a consumed instruction advances
    // the PC in the same cycle; both are held low while reset is asserted.
    assign imem_req  = (state_r == S_REQ) && !reset;
    assign imem_addr = (state_r == S_REQ) ? pc : addr_r;
    assign pc_enable = !reset && (flush || ((state_r == S_HOLD) && id_ready));

    assign id_valid  = id_valid_r;
    assign id_instr  = id_instr_r;
    assign id_pc     = id_pc_r;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_if_stage16.sv
// Directed bench for if_stage16 (TIMEOUT=4): a per-cycle vector table followed
// by hand-written reset, spurious-response and asynchronous-reset sequences.
module tb_if_stage16;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic        pc_enable;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_ready;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    if_stage16 #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_enable(pc_enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ready(id_ready), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        gnt;
        logic        rv;
        logic [15:0] rdata;
        logic        fl;
        logic        rdy;
        logic        pe;
        logic        req;
        logic [15:0] addr;
        logic        idv;
        logic [15:0] instr;
        logic [15:0] idpc;
        logic        err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int p, input int g, input int r, input int d,
                       input int f, input int y, input int e_pe, input int e_req,
                       input int e_addr, input int e_idv, input int e_instr,
                       input int e_idpc, input int e_err);
        vec_t v;
        v.pc = 16'(p); v.gnt = 1'(g); v.rv = 1'(r); v.rdata = 16'(d);
        v.fl = 1'(f); v.rdy = 1'(y);
        v.pe = 1'(e_pe); v.req = 1'(e_req); v.addr = 16'(e_addr);
        v.idv = 1'(e_idv); v.instr = 16'(e_instr); v.idpc = 16'(e_idpc);
        v.err = 1'(e_err);
        vq.push_back(v);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic g, input logic r,
                         input logic [15:0] d, input logic f, input logic y);
        pc = p; imem_gnt = g; imem_rvalid = r; imem_rdata = d; flush = f; id_ready = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // basic fetch, 1-cycle memory, consume
        add('h0010,1,0,0,0,0,       0,1,'h0010,0,0,0,0);
        add('h0010,0,1,'hA5C3,0,0,  0,0,'h0010,0,0,0,0);
        add('h0010,0,0,0,0,1,       1,0,'h0010,1,'hA5C3,'h0010,0);
        add('h0011,0,0,0,0,0,       0,1,'h0011,0,'hA5C3,'h0010,0);
        // decode stall for 5 cycles
        add('h0011,1,0,0,0,0,       0,1,'h0011,0,'hA5C3,'h0010,0);
        add('h0011,0,1,'h1234,0,0,  0,0,'h0011,0,'hA5C3,'h0010,0);
        for (int i = 0; i < 5; i++)
            add('h0011,0,0,0,0,0,   0,0,'h0011,1,'h1234,'h0011,0);
        add('h0011,0,0,0,0,1,       1,0,'h0011,1,'h1234,'h0011,0);
        add('h0012,0,0,0,0,0,       0,1,'h0012,0,'h1234,'h0011,0);
        // flush in WAIT, late response discarded in DRAIN
        add('h0020,1,0,0,0,0,       0,1,'h0020,0,'h1234,'h0011,0);
        add('h0020,0,0,0,1,0,       1,0,'h0020,0,'h1234,'h0011,0);
        add('h0040,0,0,0,0,0,       0,0,'h0020,0,'h1234,'h0011,0);
        add('h0040,0,1,'h1111,0,0,  0,0,'h0020,0,'h1234,'h0011,0);
        add('h0040,0,0,0,0,0,       0,1,'h0040,0,'h1234,'h0011,0);
        // flush together with id_ready in HOLD
        add('h0040,1,0,0,0,0,       0,1,'h0040,0,'h1234,'h0011,0);
        add('h0040,0,1,'h5678,0,0,  0,0,'h0040,0,'h1234,'h0011,0);
        add('h0040,0,0,0,1,1,       1,0,'h0040,1,'h5678,'h0040,0);
        add('h0080,0,0,0,0,0,       0,1,'h0080,0,'h5678,'h0040,0);
        add('h0080,0,0,0,0,1,       0,1,'h0080,0,'h5678,'h0040,0);
        // flush in REQ without gnt, then with gnt
        add('h0080,0,0,0,1,0,       1,1,'h0080,0,'h5678,'h0040,0);
        add('h0090,0,0,0,0,0,       0,1,'h0090,0,'h5678,'h0040,0);
        add('h0090,1,0,0,1,0,       1,1,'h0090,0,'h5678,'h0040,0);
        add('h00A0,0,1,'h2222,0,0,  0,0,'h0090,0,'h5678,'h0040,0);
        // flush in WAIT coincident with rvalid
        add('h00A0,1,0,0,0,0,       0,1,'h00A0,0,'h5678,'h0040,0);
        add('h00A0,0,1,'h3333,1,0,  1,0,'h00A0,0,'h5678,'h0040,0);
        add('h00B0,0,0,0,0,0,       0,1,'h00B0,0,'h5678,'h0040,0);
        // fetch at 0xFFFF
        add('hFFFF,1,0,0,0,0,       0,1,'hFFFF,0,'h5678,'h0040,0);
        add('hFFFF,0,1,'h4444,0,0,  0,0,'hFFFF,0,'h5678,'h0040,0);
        add('hFFFF,0,0,0,0,1,       1,0,'hFFFF,1,'h4444,'hFFFF,0);
        add('h0000,0,0,0,0,0,       0,1,'h0000,0,'h4444,'hFFFF,0);
        // timeout after 4 wait cycles, late data still loads
        add('h0000,1,0,0,0,0,       0,1,'h0000,0,'h4444,'hFFFF,0);
        for (int i = 0; i < 4; i++)
            add('h0000,0,0,0,0,0,   0,0,'h0000,0,'h4444,'hFFFF,0);
        add('h0000,0,0,0,0,0,       0,0,'h0000,0,'h4444,'hFFFF,1);
        add('h0000,0,1,'hBEEF,0,0,  0,0,'h0000,0,'h4444,'hFFFF,1);
        add('h0000,0,0,0,0,0,       0,0,'h0000,1,'hBEEF,'h0000,1);
        add('h0000,0,0,0,0,1,       1,0,'h0000,1,'hBEEF,'h0000,1);
        add('h0001,0,0,0,0,0,       0,1,'h0001,0,'hBEEF,'h0000,1);

        // reset state, with flush high to show pc_enable is forced low
        tick();
        tick();
        @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_pe", pc_enable, 1'b0);
        chk1("rst_idv", id_valid, 1'b0);
        chk16("rst_instr", id_instr, 16'h0000);
        chk16("rst_idpc", id_pc, 16'h0000);
        chk1("rst_err", fetch_err, 1'b0);
        tick();
        reset = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].pc, vq[i].gnt, vq[i].rv, vq[i].rdata, vq[i].fl, vq[i].rdy);
            @(negedge clk);
            chk1($sformatf("row%0d pc_enable", i), pc_enable, vq[i].pe);
            chk1($sformatf("row%0d imem_req", i), imem_req, vq[i].req);
            chk16($sformatf("row%0d imem_addr", i), imem_addr, vq[i].addr);
            chk1($sformatf("row%0d id_valid", i), id_valid, vq[i].idv);
            chk16($sformatf("row%0d id_instr", i), id_instr, vq[i].instr);
            chk16($sformatf("row%0d id_pc", i), id_pc, vq[i].idpc);
            chk1($sformatf("row%0d fetch_err", i), fetch_err, vq[i].err);
            tick();
        end

        // reset clears the sticky error
        drive(16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk1("err_cleared", fetch_err, 1'b0);
        tick();
        reset = 1'b0;

        // spurious rvalid in HOLD: ignored, error set
        drive(16'h0100, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(16'h0100, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0);
        tick();
        drive(16'h0100, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
        @(negedge clk);
        chk1("hold_idv", id_valid, 1'b1);
        chk1("hold_err_before", fetch_err, 1'b0);
        tick();
        drive(16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        chk16("hold_spur_instr", id_instr, 16'h7777);
        chk1("hold_spur_idv", id_valid, 1'b1);
        chk1("hold_spur_req", imem_req, 1'b0);
        chk1("hold_spur_err", fetch_err, 1'b1);

        // asynchronous reset while HOLD, checked before any clock edge
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk1("async_idv", id_valid, 1'b0);
        chk16("async_instr", id_instr, 16'h0000);
        chk16("async_idpc", id_pc, 16'h0000);
        chk1("async_req", imem_req, 1'b0);
        chk1("async_err", fetch_err, 1'b0);
        tick();
        reset = 1'b0;

        // spurious rvalid in REQ right after reset
        drive(16'h0200, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        @(negedge clk);
        chk1("req_first_req", imem_req, 1'b1);
        chk1("req_spur_err_before", fetch_err, 1'b0);
        tick();
        drive(16'h0200, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        chk1("req_spur_err", fetch_err, 1'b1);
        chk1("req_spur_req", imem_req, 1'b1);
        chk1("req_spur_idv", id_valid, 1'b0);
        chk16("req_spur_instr", id_instr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
